// File: rtl/core_tx_pkg.sv
// core_tx_pkg
// Shared definitions for the core output-path UART transmitter:
//   - core_sig command encodings driven by the pipeline
//   - serialiser state enumeration used by uart_tx_shifter
package core_tx_pkg;

  localparam logic [1:0] CORE_SIG_NONE = 2'b00;
  localparam logic [1:0] CORE_SIG_BYTE = 2'b10;
  localparam logic [1:0] CORE_SIG_WORD = 2'b11;

  // PARITY is only ever entered when CORE_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } txState_e;

endpackage

// File: rtl/uart_tx_shifter.sv
// uart_tx_shifter
// Serialises one byte per frame onto a registered txd line: start bit,
// 8 data bits LSB first, optional even-parity bit, stop bit. A new byte is
// taken over the valid/ready handshake either from IDLE or at the very end
// of a stop bit, so queued bytes go out back-to-back with no idle gap.
// Optional feature macro: CORE_TX_PARITY_EN (adds the PARITY state).
// Ports:
//   clk_i, rst_i    core clock, synchronous active-high reset
//   data_i, valid_i byte offered by the FIFO and its non-empty flag
//   ready_o         high on the cycle the shifter pops a byte
//   txd_o           serial line, idle high
//   idle_o          high once the FSM is idle and the last stop bit is on the wire
module uart_tx_shifter
  import core_tx_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 521
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o,
  output logic       idle_o
);

  localparam int TW = (2 * CLK_PER_HALF_BIT > 1) ? $clog2(2 * CLK_PER_HALF_BIT) : 1;
  localparam logic [TW-1:0] TIMER_MAX = TW'(2 * CLK_PER_HALF_BIT - 1);

  txState_e      state_q;
  logic [TW-1:0] timer_q;
  logic [2:0]    bitIdx_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          lineIdle_q;
  logic          timerEnd;
  logic          load;
  logic          lineLevel;
`ifdef CORE_TX_PARITY_EN
  logic          parity_q;
`endif

  assign timerEnd = (timer_q == TIMER_MAX);
  assign ready_o  = (state_q == IDLE) || ((state_q == STOP) && timerEnd);
  assign load     = valid_i && ready_o;
  assign txd_o    = txd_q;
  // lineIdle_q lags the state by one cycle, matching txd_q, so idle_o only
  // rises after the final stop bit has fully left the register.
  assign idle_o   = (state_q == IDLE) && lineIdle_q;

  // Line level implied by the current state; registered into txd_q below.
  always_comb begin
    lineLevel = 1'b1;
    case (state_q)
      START:   lineLevel = 1'b0;
      DATA:    lineLevel = shift_q[0];
`ifdef CORE_TX_PARITY_EN
      PARITY:  lineLevel = parity_q;
`endif
      default: lineLevel = 1'b1;
    endcase
  end

  // Serialiser FSM, bit timer, bit index, shift register and txd register.
  // Every state transition happens on timerEnd, when the timer wraps to 0,
  // so the timer restarts on each state entry; IDLE holds it at 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      txd_q      <= 1'b1;
      lineIdle_q <= 1'b1;
`ifdef CORE_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      txd_q      <= lineLevel;
      lineIdle_q <= (state_q == IDLE);

      if (state_q == IDLE || timerEnd) timer_q <= '0;
      else                             timer_q <= timer_q + TW'(1);

      if (load) begin
        shift_q  <= data_i;
`ifdef CORE_TX_PARITY_EN
        parity_q <= ^data_i;
`endif
      end else if (state_q == DATA && timerEnd) begin
        shift_q  <= shift_q >> 1;
      end

      case (state_q)
        IDLE: begin
          if (load) state_q <= START;
        end
        START: begin
          if (timerEnd) begin
            state_q  <= DATA;
            bitIdx_q <= '0;
          end
        end
        DATA: begin
          if (timerEnd) begin
            if (bitIdx_q == 3'd7) begin
`ifdef CORE_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bitIdx_q <= bitIdx_q + 3'd1;
            end
          end
        end
        PARITY: begin
          if (timerEnd) state_q <= STOP;
        end
        STOP: begin
          if (timerEnd) state_q <= load ? START : IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/core_tx_buffer.sv
// core_tx_buffer
// Byte-buffered UART transmitter for the core output path. Output commands
// push 1 or 4 bytes into a circular FIFO; uart_tx_shifter drains it onto txd.
// output_stall is raised while fewer than 4 bytes are free, so a word push
// always fits whenever stall is low; commands seen during stall are dropped.
// Optional feature macro: CORE_TX_PARITY_EN (even parity bit, 11-bit frames).
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   send_data     32-bit payload, byte [7:0] sent first
//   core_sig      00/01 none, 10 send one byte, 11 send four bytes
//   output_stall  fewer than 4 bytes free
//   txd           serial line, idle high
//   tx_empty      FIFO empty and serialiser fully idle
//   fifo_count    bytes currently queued
module core_tx_buffer
  import core_tx_pkg::*;
#(
  parameter int CLK_PER_HALF_BIT = 521,
  parameter int FIFO_DEPTH_LOG2  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              send_data,
  input  logic [1:0]               core_sig,
  output logic                     output_stall,
  output logic                     txd,
  output logic                     tx_empty,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  localparam int N     = FIFO_DEPTH_LOG2;
  localparam int DEPTH = 1 << N;
  localparam int CW    = N + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [N-1:0]  wrPtr_q;
  logic [N-1:0]  rdPtr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic [CW-1:0] freeSlots;
  logic [2:0]    nPush;
  logic          accept;
  logic          isWord;
  logic          pop;
  logic          shReady;
  logic          shIdle;

  assign freeSlots    = CW'(DEPTH) - count_q;
  assign output_stall = (freeSlots < CW'(4));
  assign accept       = core_sig[1] && !output_stall;
  assign isWord       = (core_sig == CORE_SIG_WORD);
  assign nPush        = accept ? (isWord ? 3'd4 : 3'd1) : 3'd0;
  // Valid comes from the registered count, so a byte pushed this cycle
  // cannot be popped until the next one.
  assign pop          = shReady && (count_q != '0);
  assign count_d      = count_q + CW'(nPush) - CW'(pop);
  assign fifo_count   = count_q;
  assign tx_empty     = (count_q == '0) && shIdle;

  // Byte storage; pointer arithmetic wraps naturally at N bits.
  always_ff @(posedge clk) begin
    if (accept) begin
      mem_q[wrPtr_q] <= send_data[7:0];
      if (isWord) begin
        mem_q[wrPtr_q + N'(1)] <= send_data[15:8];
        mem_q[wrPtr_q + N'(2)] <= send_data[23:16];
        mem_q[wrPtr_q + N'(3)] <= send_data[31:24];
      end
    end
  end

  // Pointers and occupancy counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (accept) wrPtr_q <= wrPtr_q + (isWord ? N'(4) : N'(1));
      if (pop)    rdPtr_q <= rdPtr_q + N'(1);
      count_q <= count_d;
    end
  end

  uart_tx_shifter #(
    .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
  ) uShifter (
    .clk_i  (clk),
    .rst_i  (rst),
    .data_i (mem_q[rdPtr_q]),
    .valid_i(count_q != '0),
    .ready_o(shReady),
    .txd_o  (txd),
    .idle_o (shIdle)
  );

endmodule

// File: tb/tb_core_tx_buffer.sv
// tb_core_tx_buffer
// Scoreboard bench for core_tx_buffer. The stimulus side keeps a
// transaction-level model (bytes queued, cycles left in the current frame)
// and pushes every accepted byte into expQ; an independent UART receiver
// decodes txd and pops expQ for each frame it sees.
module tb_core_tx_buffer;
  import core_tx_pkg::*;

  localparam int HALF  = 4;
  localparam int NLOG  = 4;
  localparam int DEPTH = 16;
  localparam int BITC  = 2 * HALF;
`ifdef CORE_TX_PARITY_EN
  localparam int FRAME = 11 * BITC;
`else
  localparam int FRAME = 10 * BITC;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   send_data = '0;
  logic [1:0]    core_sig = CORE_SIG_NONE;
  logic          output_stall;
  logic          txd;
  logic          tx_empty;
  logic [NLOG:0] fifo_count;

  core_tx_buffer #(
    .CLK_PER_HALF_BIT(HALF),
    .FIFO_DEPTH_LOG2 (NLOG)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send_data   (send_data),
    .core_sig    (core_sig),
    .output_stall(output_stall),
    .txd         (txd),
    .tx_empty    (tx_empty),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Free-running cycle counter used to timestamp frame starts.
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] expQ[$];
  int         startQ[$];
  int         mCount = 0;
  int         frameLeft = 0;
  int         prevFrameLeft = 0;
  int         gen = 0;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Compare the visible status outputs with the model after an edge.
  task automatic checkOutput();
    checkValue("fifo_count", 32'(fifo_count), 32'(mCount));
    checkValue("output_stall", 32'(output_stall), ((DEPTH - mCount) < 4) ? 32'd1 : 32'd0);
    checkValue("tx_empty", 32'(tx_empty),
               (mCount == 0 && frameLeft == 0 && prevFrameLeft == 0) ? 32'd1 : 32'd0);
  endtask

  // Drive one command for one edge, advance the model, then check.
  // The serialiser may take a byte when idle or on the last cycle of a
  // frame; a frame lasts FRAME cycles from the pop.
  task automatic applyStimulus(input logic [1:0] sig, input logic [31:0] data);
    bit popNow;
    bit acceptNow;
    @(negedge clk);
    rst       = 1'b0;
    core_sig  = sig;
    send_data = data;
    @(posedge clk);
    popNow    = (frameLeft <= 1) && (mCount > 0);
    acceptNow = sig[1] && ((DEPTH - mCount) >= 4);
    if (acceptNow) begin
      expQ.push_back(data[7:0]);
      if (sig[0]) begin
        expQ.push_back(data[15:8]);
        expQ.push_back(data[23:16]);
        expQ.push_back(data[31:24]);
      end
    end
    prevFrameLeft = frameLeft;
    frameLeft = popNow ? FRAME : ((frameLeft > 0) ? frameLeft - 1 : 0);
    mCount = mCount + (acceptNow ? (sig[0] ? 4 : 1) : 0) - (popNow ? 1 : 0);
    #1 checkOutput();
  endtask

  task automatic applyReset();
    @(negedge clk);
    rst      = 1'b1;
    core_sig = CORE_SIG_NONE;
    @(posedge clk);
    mCount = 0;
    frameLeft = 0;
    prevFrameLeft = 0;
    expQ.delete();
    gen++;
    #1 checkOutput();
    checkValue("reset_txd", 32'(txd), 32'd1);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(expQ.size() == 0 && mCount == 0 && frameLeft == 0 && prevFrameLeft == 0) && n < budget) begin
      applyStimulus(CORE_SIG_NONE, 32'h0);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("[TB] FAIL drain: %0d bytes still expected after %0d cycles", expQ.size(), n);
    end
  endtask

  // UART receiver: samples mid-bit on negedges and scores each frame.
  logic [7:0] monByte;
  bit         monOk;
  int         monGen;
  int         monStart;
  logic [7:0] monExp;

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (txd === 1'b0) begin
        monGen   = gen;
        monStart = cyc;
        monOk    = 1'b1;
        repeat (HALF) @(negedge clk);
        if (txd !== 1'b0) monOk = 1'b0;
        for (int k = 0; k < 8; k++) begin
          repeat (BITC) @(negedge clk);
          monByte[k] = txd;
        end
`ifdef CORE_TX_PARITY_EN
        repeat (BITC) @(negedge clk);
        if (txd !== ^monByte) monOk = 1'b0;
`endif
        repeat (BITC) @(negedge clk);
        if (txd !== 1'b1) monOk = 1'b0;
        if (monGen == gen) begin
          startQ.push_back(monStart);
          total++;
          if (expQ.size() == 0) begin
            bad++;
            $display("[TB] FAIL frame: unexpected byte %02h received", monByte);
          end else begin
            monExp = expQ.pop_front();
            if (!monOk || monByte !== monExp) begin
              bad++;
              $display("[TB] FAIL frame: got %02h (framing ok=%0d) expected %02h", monByte, monOk, monExp);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    int c;
    int v;
    int n;
    int lowSeen;

    applyReset();
    applyReset();

    // Single byte with exact txd fall timing.
    $display("[TB] single byte");
    applyStimulus(CORE_SIG_BYTE, 32'h000000A5);
    checkValue("single_txd_e0", 32'(txd), 32'd1);
    applyStimulus(CORE_SIG_NONE, 32'h0);
    checkValue("single_txd_e1", 32'(txd), 32'd1);
    applyStimulus(CORE_SIG_NONE, 32'h0);
    checkValue("single_txd_fall", 32'(txd), 32'd0);
    drain(400);

    // Word: four frames back-to-back.
    $display("[TB] word");
    startQ.delete();
    applyStimulus(CORE_SIG_WORD, 32'h44332211);
    drain(600);
    checkValue("word_frames", 32'(startQ.size()), 32'd4);
    for (int k = 1; k < startQ.size(); k++)
      checkValue("word_gap", 32'(startQ[k] - startQ[k-1]), 32'(FRAME));

    // Fill until stall, then a dropped word.
    $display("[TB] stall");
    repeat (4) applyStimulus(CORE_SIG_WORD, $urandom);
    checkValue("stall_high", 32'(output_stall), 32'd1);
    c = mCount;
    applyStimulus(CORE_SIG_WORD, $urandom);
    checkValue("stall_drop", 32'(fifo_count), 32'(c));
    drain(3000);

    // Push on the same edge as the stop-to-start pop.
    $display("[TB] push/pop same edge");
    applyStimulus(CORE_SIG_BYTE, 32'h5A);
    applyStimulus(CORE_SIG_BYTE, 32'h3C);
    n = 0;
    while (frameLeft != 1 && n < 200) begin
      applyStimulus(CORE_SIG_NONE, 32'h0);
      n++;
    end
    applyStimulus(CORE_SIG_BYTE, 32'hC3);
    checkValue("push_pop_same_edge", 32'(fifo_count), 32'd1);
    drain(1000);

    // Pointer wrap: 40 sequential bytes.
    $display("[TB] wrap");
    v = 0;
    n = 0;
    while (v < 40 && n < 6000) begin
      if ((DEPTH - mCount) < 4) applyStimulus(CORE_SIG_NONE, 32'h0);
      else begin
        applyStimulus(CORE_SIG_BYTE, 32'(v));
        v++;
      end
      n++;
    end
    drain(4000);

    // Random commands.
    $display("[TB] random");
    repeat (400) applyStimulus(2'($urandom_range(0, 3)), $urandom);
    drain(3000);

    // Reset during DATA with five bytes queued.
    $display("[TB] reset mid-frame");
    applyStimulus(CORE_SIG_WORD, $urandom);
    applyStimulus(CORE_SIG_BYTE, $urandom);
    repeat (30) applyStimulus(CORE_SIG_NONE, 32'h0);
    applyReset();
    lowSeen = 0;
    repeat (200) begin
      applyStimulus(CORE_SIG_NONE, 32'h0);
      if (txd !== 1'b1) lowSeen++;
    end
    checkValue("quiet_after_reset", 32'(lowSeen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_tx_buffer.md
# core_tx_buffer

Byte-buffered UART transmitter for the core's output path, on the same serial link as the `input_fifo` receiver but in the opposite direction. Accepts 1-byte or 4-byte output commands from the pipeline (`send_data` and `core_sig`) and queues the bytes in an internal FIFO. Serialises them 8N1 on `txd`. Raises `output_stall` so the core holds its output instruction until there is room. Runs entirely in the core clock domain.

## Interface
Parameters:
- `CLK_PER_HALF_BIT`, default 521: core-clock cycles per half UART bit; one bit period is 2×`CLK_PER_HALF_BIT` cycles.
- `FIFO_DEPTH_LOG2`, default 4: the FIFO holds 2^N bytes; N must be ≥ 3.

Ports:
- `clk`  in  1: core clock.
- `rst`  in  1: synchronous reset, active-high.
- `send_data`  in  32: output payload.
- `core_sig`  in  2: command. 00/01 = none, 10 = send `send_data[7:0]`, 11 = send all four bytes.
- `output_stall`  out  1: high when fewer than 4 bytes are free; commands are ignored while it is high.
- `txd`  out  1: serial line, idle high.
- `tx_empty`  out  1: FIFO empty and the serialiser is idle.
- `fifo_count`  out  FIFO_DEPTH_LOG2+1: number of bytes currently queued.

## Operation
- A command is accepted on a clock edge where `core_sig[1]`=1 and `output_stall`=0.
  - 10 pushes 1 byte.
  - 11 pushes 4 bytes in one cycle, in the order `[7:0]`, `[15:8]`, `[23:16]`, `[31:24]`; the first pushed byte is the first transmitted.
- A command issued while `output_stall`=1 is dropped silently. The core is responsible for re-issuing it.
- FIFO: a byte array with read and write pointers of FIFO_DEPTH_LOG2 bits that wrap modulo the depth. `fifo_count` is a separate counter.
  - When a push and a pop happen in the same cycle, count' = count + n_push − 1.
- `output_stall` = (2^N − `fifo_count`) < 4. It is combinational from the registered count, so a 4-byte push is always accepted whenever stall is low.
- Serialiser FSM:
  - IDLE: `txd`=1. If the FIFO is non-empty, pop the head byte into the shift register and go to START.
  - START: `txd`=0 for one bit period, then DATA.
  - DATA: 8 bits, LSB first, one bit period each, then STOP. With the parity option, PARITY comes between DATA and STOP.
  - STOP: `txd`=1 for one bit period. At the end of the period, if the FIFO is non-empty, pop the next byte and go directly to START with no idle gap; otherwise go to IDLE.
- The bit timer counts 0..2×`CLK_PER_HALF_BIT`−1 and the bit index counts 0..7. Both reset on every state entry.

## Timing
- Reset values (the cycle after an edge with `rst`=1):
  - `txd`=1, `output_stall`=0, `tx_empty`=1, `fifo_count`=0.
  - Pointers are 0 and the FSM is in IDLE.
- Reset mid-frame truncates the frame: `txd` returns high the cycle after reset and the queued bytes are discarded.
- Latency from an accepting edge E with the FIFO empty and the FSM in IDLE:
  - `fifo_count` updates after E.
  - The pop happens at E+1.
  - `txd` falls after E+2.
- Frame length is 10 bit periods, or 11 with parity. `txd` is registered.
- `tx_empty` falls after E and rises only once the last stop bit is complete.
- A pop and a push in the same cycle on an empty FIFO cannot happen; the pop sees count 0 and the FSM waits one more cycle.

## Configuration
- `CORE_TX_PARITY_EN` defined: an even-parity bit (XOR of the 8 data bits) is sent after DATA, giving 11-bit frames.
- Not defined: plain 8N1 with 10-bit frames and no PARITY state.

## Structure
- Package `core_tx_pkg` contains:
  - The `core_sig` encoding constants (`CORE_SIG_NONE`, `CORE_SIG_BYTE`=2'b10, `CORE_SIG_WORD`=2'b11).
  - The serialiser state enum (IDLE, START, DATA, PARITY, STOP).
- Sub-module `uart_tx_shifter` contains the FSM, bit timer, shift register and `txd`. It has a valid/ready byte input. The FIFO and stall logic stay in the top module.

## Test plan
All scenarios use `CLK_PER_HALF_BIT`=4 (8-cycle bits) and depth 16.
- Single byte: `core_sig`=10 with `send_data`=0x000000A5 → `txd` low 2 cycles after accept, then bits 1,0,1,0,0,1,0,1 for 8 cycles each, then a stop bit. `tx_empty` rises 80 cycles after `txd` first falls.
- Word: `core_sig`=11 with `send_data`=0x44332211 → frames 0x11, 0x22, 0x33, 0x44 back-to-back with no idle gap between stop and start; total 320 cycles.
- Full/stall: issue four word commands back-to-back → the fourth is accepted only if `fifo_count`≤12; once the count reaches 13, stall is 1 and a word command is dropped with `fifo_count` unchanged.
- Simultaneous push/pop: with count=1, issue a byte command on the same edge as the STOP→START pop → `fifo_count` stays 1.
- Pointer wrap: push 40 bytes with values 0..39 while respecting stall → all 40 are received in order on `txd`.
- Reset mid-frame: assert `rst` during the DATA state with 5 bytes queued → the next cycle shows `txd`=1, `fifo_count`=0, `tx_empty`=1, and no further frames appear.
